// File: rtl/solver_in_pio_edge.sv
// solver_in_pio_edge: Avalon-MM input PIO with synchroniser, sticky edge capture and maskable level IRQ
module solver_in_pio_edge #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [SYNC_STAGES:0]              r_fill;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_edge;
  logic [WIDTH-1:0]                  r_mask;
  logic [WIDTH-1:0]                  w_sync;
  logic [WIDTH-1:0]                  w_rise;
  logic [WIDTH-1:0]                  w_fall;
  logic [WIDTH-1:0]                  w_det;
  logic [WIDTH-1:0]                  w_clr;
  logic                              w_wr;
  logic [31:0]                       w_rd;
  logic                              w_unused;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_wr     = chipselect & ~write_n;
  assign w_unused = ^writedata;

  // edge detect, held off until sync and prev have both filled from the pin after reset
  always_comb begin
    w_rise = w_sync & ~r_prev;
    w_fall = ~w_sync & r_prev;
    w_det  = (EDGE_TYPE == 0 ? w_rise : EDGE_TYPE == 1 ? w_fall : (w_rise | w_fall)) & {WIDTH{r_fill[SYNC_STAGES]}};
    w_clr  = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    w_rd   = address == 2'd0 ? 32'(w_sync) :
             address == 2'd2 ? 32'(r_mask) :
             address == 2'd3 ? 32'(r_edge) : '0;
  end

  // synchroniser chain, fill tracker and previous sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_fill <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
      r_prev <= w_sync;
    end
  end

  // sticky edge bits (set beats W1C), mask register, irq and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge   <= '0;
      r_mask   <= RESET_MASK;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      r_edge   <= w_det | (r_edge & ~w_clr);
      if (w_wr && address == 2'd2) r_mask <= writedata[WIDTH-1:0];
      irq      <= |(r_edge & r_mask);
      readdata <= w_rd;
    end
  end
endmodule

// File: tb/tb_solver_in_pio_edge.sv
// tb_solver_in_pio_edge: directed checks of rising and any-edge instances sharing one bus
module tb_solver_in_pio_edge;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd0, rd2;
  logic        irq0, irq2;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  solver_in_pio_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_MASK(8'h00)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));

  solver_in_pio_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .RESET_MASK(8'h00)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    step(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    step(1);
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; in_port = 8'h05;
    step(2);
    chk("rst_rd", rd0, 32'h0);
    chk("rst_irq", {31'b0, irq0}, 32'h0);
    reset_n = 1'b1;
    step(5);
    rd(2'd0); chk("data05_r", rd0, 32'h05); chk("data05_a", rd2, 32'h05);
    rd(2'd3); chk("cap0_r", rd0, 32'h0); chk("cap0_a", rd2, 32'h0);
    chk("irq0_init", {31'b0, irq0}, 32'h0);

    in_port = 8'h00;
    step(5);
    rd(2'd3); chk("fall_a", rd2, 32'h05); chk("fall_r", rd0, 32'h0);
    chk("irq_masked", {31'b0, irq2}, 32'h0);
    wr(2'd2, 32'h04);
    step(1);
    chk("irq_unmask_a", {31'b0, irq2}, 32'h1);
    chk("irq_unmask_r", {31'b0, irq0}, 32'h0);
    wr(2'd3, 32'hFF);
    chk("w1c_irq_hold", {31'b0, irq2}, 32'h1);
    step(1);
    chk("w1c_irq_drop", {31'b0, irq2}, 32'h0);
    rd(2'd3); chk("w1c_cap_a", rd2, 32'h0);

    wr(2'd2, 32'h01);
    in_port = 8'h01;
    step(1);
    in_port = 8'h00;
    step(2);
    chk("pulse_irq_early", {31'b0, irq0}, 32'h0);
    step(1);
    chk("pulse_irq", {31'b0, irq0}, 32'h1);
    rd(2'd3); chk("pulse_cap", rd0, 32'h01);
    wr(2'd3, 32'h01);
    chk("pulse_w1c_hold", {31'b0, irq0}, 32'h1);
    step(1);
    chk("pulse_w1c_drop", {31'b0, irq0}, 32'h0);
    rd(2'd3); chk("pulse_cap_clr", rd0, 32'h0);

    in_port = 8'h04;
    step(2);
    wr(2'd3, 32'h04);
    rd(2'd3); chk("set_wins", rd0, 32'h04);
    wr(2'd3, 32'h04);
    rd(2'd3); chk("w1c_bit2", rd0, 32'h0);

    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2); chk("mask_width", rd0, 32'hFF);
    rd(2'd1); chk("rsvd", rd0, 32'h0);
    rd(2'd0); chk("data04", rd0, 32'h04);

    in_port = 8'h00;
    step(5);
    wr(2'd3, 32'hFF);
    in_port = 8'h0F;
    step(5);
    rd(2'd3); chk("cap0f", rd0, 32'h0F);
    chk("irq_pre_rst", {31'b0, irq0}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_rd", rd0, 32'h0);
    chk("async_irq", {31'b0, irq0}, 32'h0);
    step(1);
    reset_n = 1'b1;
    step(6);
    rd(2'd3); chk("no_false_rise", rd0, 32'h0);
    chk("irq_post_rst", {31'b0, irq0}, 32'h0);
    rd(2'd2); chk("mask_rst", rd0, 32'h0);
    rd(2'd0); chk("data0f", rd0, 32'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
